csr_file: RTL and testbench

Machine-mode control and status register file for the rv32i core. Sits directly downstream of the CSR decoder in the control unit: it consumes the decoder's `csr_w` and `csr_data_s` strobes, supplies read data to the writeback mux that the decoder's `data_read_sel` steers, and owns trap entry (ecall/ebreak), `mret` return and the 64-bit cycle and instret counters.

---
 rtl/csr_file_if.sv | 29 ++
 rtl/csr_file.sv | 137 +++++++++++++
 tb/tb_csr_file.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_file_if.sv
// CSR file bus: decoder strobes, read data and PC redirect.
// master = control unit side, slave = csr_file.
interface csr_file_if;
    logic        csr_w;
    logic        csr_data_s;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  uimm;
    logic [31:0] pc;
    logic        retire;
    logic        ecall;
    logic        ebreak;
    logic        mret;
    logic [31:0] csr_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output csr_w, csr_data_s, csr_addr, rs1_data, uimm,
        output pc, retire, ecall, ebreak, mret,
        input  csr_rdata, redirect, redirect_pc
    );

    modport slave (
        input  csr_w, csr_data_s, csr_addr, rs1_data, uimm,
        input  pc, retire, ecall, ebreak, mret,
        output csr_rdata, redirect, redirect_pc
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap entry/mret, 64-bit cycle/instret counters.
// Ports: clk, rst_n (async active-low), bus (csr_file_if.slave).
module csr_file #(
    parameter logic [31:0] HART_ID   = 32'd0,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    csr_file_if.slave  bus
);
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    logic        mie;
    logic        mpie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic        trap;
    logic        wr_en;
    logic [31:0] wdata;
    logic [31:0] mstatus;
    logic        inst_inc;

    // ecall outranks ebreak outranks mret; any of them masks csr_w
    assign trap     = bus.ecall | bus.ebreak;
    assign wr_en    = bus.csr_w & ~(trap | bus.mret);
    assign wdata    = bus.csr_data_s ? {27'b0, bus.uimm} : bus.rs1_data;
    assign mstatus  = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
    assign inst_inc = bus.retire & ~trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= MTVEC_RST;
            mscratch <= 32'd0;
            mepc     <= 32'd0;
            mcause   <= 32'd0;
        end else if (trap) begin
            mepc   <= bus.pc & ~32'd3;
            mcause <= bus.ecall ? 32'd11 : 32'd3;
            mpie   <= mie;
            mie    <= 1'b0;
        end else if (bus.mret) begin
            mie  <= mpie;
            mpie <= 1'b1;
        end else if (wr_en) begin
            case (bus.csr_addr)
                A_MSTATUS: begin
                    mie  <= wdata[3];
                    mpie <= wdata[7];
                end
                A_MTVEC:    mtvec    <= wdata & ~32'd3;
                A_MSCRATCH: mscratch <= wdata;
                A_MEPC:     mepc     <= wdata & ~32'd3;
                A_MCAUSE:   mcause   <= wdata;
                default: ;
            endcase
        end
    end

    // a write to one half beats the increment; the other half holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle <= 64'd0;
        end else if (wr_en && bus.csr_addr == A_MCYCLE) begin
            mcycle[31:0] <= wdata;
        end else if (wr_en && bus.csr_addr == A_MCYCLEH) begin
            mcycle[63:32] <= wdata;
        end else begin
            mcycle <= mcycle + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            minstret <= 64'd0;
        end else if (wr_en && bus.csr_addr == A_MINSTRET) begin
            minstret[31:0] <= wdata;
        end else if (wr_en && bus.csr_addr == A_MINSTRETH) begin
            minstret[63:32] <= wdata;
        end else if (inst_inc) begin
            minstret <= minstret + 64'd1;
        end
    end

    always_comb begin
        bus.csr_rdata = 32'd0;
        case (bus.csr_addr)
            A_MSTATUS:               bus.csr_rdata = mstatus;
            A_MISA:                  bus.csr_rdata = 32'h4000_0100;
            A_MTVEC:                 bus.csr_rdata = mtvec;
            A_MSCRATCH:              bus.csr_rdata = mscratch;
            A_MEPC:                  bus.csr_rdata = mepc;
            A_MCAUSE:                bus.csr_rdata = mcause;
            A_MCYCLE, A_CYCLE:       bus.csr_rdata = mcycle[31:0];
            A_MCYCLEH, A_CYCLEH:     bus.csr_rdata = mcycle[63:32];
            A_MINSTRET, A_INSTRET:   bus.csr_rdata = minstret[31:0];
            A_MINSTRETH, A_INSTRETH: bus.csr_rdata = minstret[63:32];
            A_MHARTID:               bus.csr_rdata = HART_ID;
            default:                 bus.csr_rdata = 32'd0;
        endcase
    end

    // held quiet during reset so no stray strobe redirects fetch
    always_comb begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        if (rst_n) begin
            if (trap) begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = mtvec;
            end else if (bus.mret) begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = mepc;
            end
        end
    end
endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file.
// Inputs change 1 time unit after the rising edge; checks follow.
module tb_csr_file;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    csr_file_if bus ();

    csr_file #(
        .HART_ID   (32'd3),
        .MTVEC_RST (32'h0000_0040)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.csr_w      = 1'b0;
        bus.csr_data_s = 1'b0;
        bus.csr_addr   = 12'h000;
        bus.rs1_data   = 32'd0;
        bus.uimm       = 5'd0;
        bus.pc         = 32'd0;
        bus.retire     = 1'b0;
        bus.ecall      = 1'b0;
        bus.ebreak     = 1'b0;
        bus.mret       = 1'b0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        bus.csr_w      = 1'b1;
        bus.csr_data_s = 1'b0;
        bus.csr_addr   = a;
        bus.rs1_data   = d;
        tick();
        bus.csr_w      = 1'b0;
    endtask

    task automatic test_reset;
        logic [11:0] a [6];
        logic [31:0] e [6];
        a = '{12'h300, 12'h301, 12'h305, 12'hF14, 12'hB00, 12'h340};
        e = '{32'h0000_1800, 32'h4000_0100, 32'h0000_0040,
              32'h0000_0003, 32'h0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            bus.csr_addr = a[i];
            #1;
            checks++;
            if (bus.csr_rdata !== e[i]) begin
                errors++;
                $display("FAIL reset_rd_%h got %h exp %h",
                         a[i], bus.csr_rdata, e[i]);
            end
        end
        checks++;
        if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_redirect got %b/%h exp 0/0",
                     bus.redirect, bus.redirect_pc);
        end
        rst_n = 1'b1;
        bus.csr_addr = 12'hB00;
        tick();
        checks++;
        if (bus.csr_rdata !== 32'd1) begin
            errors++;
            $display("FAIL reset_first_cycle got %h exp 1", bus.csr_rdata);
        end
    endtask

    task automatic test_csrrw;
        bus.csr_w      = 1'b1;
        bus.csr_data_s = 1'b0;
        bus.csr_addr   = 12'h340;
        bus.rs1_data   = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.csr_rdata !== 32'd0) begin
            errors++;
            $display("FAIL csrrw_old got %h exp 0", bus.csr_rdata);
        end
        tick();
        bus.csr_w = 1'b0;
        #1;
        checks++;
        if (bus.csr_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL csrrw_new got %h exp deadbeef", bus.csr_rdata);
        end
        csr_write(12'h341, 32'h0000_1003);
        #1;
        checks++;
        if (bus.csr_rdata !== 32'h0000_1000) begin
            errors++;
            $display("FAIL mepc_align got %h exp 1000", bus.csr_rdata);
        end
        csr_write(12'h7C0, 32'h1234_5678);
        #1;
        checks++;
        if (bus.csr_rdata !== 32'd0) begin
            errors++;
            $display("FAIL unmapped got %h exp 0", bus.csr_rdata);
        end
    endtask

    task automatic test_csrrwi;
        bus.csr_w      = 1'b1;
        bus.csr_data_s = 1'b1;
        bus.uimm       = 5'h1F;
        bus.rs1_data   = 32'hFFFF_FFFF;
        bus.csr_addr   = 12'h305;
        tick();
        bus.csr_w = 1'b0;
        #1;
        checks++;
        if (bus.csr_rdata !== 32'h0000_001C) begin
            errors++;
            $display("FAIL csrrwi_mtvec got %h exp 1c", bus.csr_rdata);
        end
        bus.csr_data_s = 1'b0;
        csr_write(12'h301, 32'h0);
        #1;
        checks++;
        if (bus.csr_rdata !== 32'h4000_0100) begin
            errors++;
            $display("FAIL misa_ro got %h exp 40000100", bus.csr_rdata);
        end
    endtask

    task automatic test_trap;
        csr_write(12'h305, 32'h0000_0100);
        csr_write(12'h300, 32'h0000_0008);
        bus.ecall = 1'b1;
        bus.pc    = 32'h0000_002C;
        #1;
        checks++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h100) begin
            errors++;
            $display("FAIL ecall_redirect got %b/%h exp 1/100",
                     bus.redirect, bus.redirect_pc);
        end
        tick();
        bus.ecall = 1'b0;
        bus.csr_addr = 12'h341;
        #1;
        checks++;
        if (bus.csr_rdata !== 32'h2C) begin
            errors++;
            $display("FAIL ecall_mepc got %h exp 2c", bus.csr_rdata);
        end
        bus.csr_addr = 12'h342;
        #1;
        checks++;
        if (bus.csr_rdata !== 32'd11) begin
            errors++;
            $display("FAIL ecall_mcause got %h exp b", bus.csr_rdata);
        end
        bus.csr_addr = 12'h300;
        #1;
        checks++;
        if (bus.csr_rdata !== 32'h0000_1880) begin
            errors++;
            $display("FAIL ecall_mstatus got %h exp 1880", bus.csr_rdata);
        end
        tick();
        bus.mret = 1'b1;
        #1;
        checks++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h2C) begin
            errors++;
            $display("FAIL mret_redirect got %b/%h exp 1/2c",
                     bus.redirect, bus.redirect_pc);
        end
        tick();
        bus.mret = 1'b0;
        #1;
        checks++;
        if (bus.csr_rdata !== 32'h0000_1888) begin
            errors++;
            $display("FAIL mret_mstatus got %h exp 1888", bus.csr_rdata);
        end
        checks++;
        if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'd0) begin
            errors++;
            $display("FAIL idle_redirect got %b/%h exp 0/0",
                     bus.redirect, bus.redirect_pc);
        end
    endtask

    task automatic test_counters;
        csr_write(12'hB00, 32'hFFFF_FFFF);
        csr_write(12'hB80, 32'hFFFF_FFFF);
        bus.csr_addr = 12'hB00;
        #1;
        checks++;
        if (bus.csr_rdata !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mcycle_hold got %h exp ffffffff", bus.csr_rdata);
        end
        tick();
        checks++;
        if (bus.csr_rdata !== 32'd0) begin
            errors++;
            $display("FAIL mcycle_wrap got %h exp 0", bus.csr_rdata);
        end
        bus.csr_addr = 12'hC80;
        #1;
        checks++;
        if (bus.csr_rdata !== 32'd0) begin
            errors++;
            $display("FAIL mcycleh_wrap got %h exp 0", bus.csr_rdata);
        end
        csr_write(12'hB02, 32'h0);
        csr_write(12'hB82, 32'h0);
        bus.retire = 1'b1;
        tick();
        tick();
        tick();
        bus.retire = 1'b0;
        bus.csr_addr = 12'hC02;
        #1;
        checks++;
        if (bus.csr_rdata !== 32'd3) begin
            errors++;
            $display("FAIL minstret_3 got %h exp 3", bus.csr_rdata);
        end
        csr_write(12'hB02, 32'hFFFF_FFFF);
        bus.retire = 1'b1;
        tick();
        bus.ebreak = 1'b1;
        tick();
        bus.retire = 1'b0;
        bus.ebreak = 1'b0;
        bus.csr_addr = 12'hB02;
        #1;
        checks++;
        if (bus.csr_rdata !== 32'd0) begin
            errors++;
            $display("FAIL minstret_carry_lo got %h exp 0", bus.csr_rdata);
        end
        bus.csr_addr = 12'hB82;
        #1;
        checks++;
        if (bus.csr_rdata !== 32'd1) begin
            errors++;
            $display("FAIL minstret_carry_hi got %h exp 1", bus.csr_rdata);
        end
    endtask

    task automatic test_conflicts;
        csr_write(12'h340, 32'h0000_1234);
        bus.ecall    = 1'b1;
        bus.mret     = 1'b1;
        bus.csr_w    = 1'b1;
        bus.csr_addr = 12'h340;
        bus.rs1_data = 32'h5555_5555;
        bus.pc       = 32'h0000_0083;
        #1;
        checks++;
        if (bus.redirect_pc !== 32'h100) begin
            errors++;
            $display("FAIL conflict_target got %h exp 100", bus.redirect_pc);
        end
        tick();
        idle();
        bus.csr_addr = 12'h340;
        #1;
        checks++;
        if (bus.csr_rdata !== 32'h0000_1234) begin
            errors++;
            $display("FAIL conflict_mscratch got %h exp 1234", bus.csr_rdata);
        end
        bus.csr_addr = 12'h341;
        #1;
        checks++;
        if (bus.csr_rdata !== 32'h80) begin
            errors++;
            $display("FAIL conflict_mepc got %h exp 80", bus.csr_rdata);
        end
        bus.ebreak = 1'b1;
        bus.mret   = 1'b1;
        bus.pc     = 32'h0000_0200;
        tick();
        idle();
        bus.csr_addr = 12'h342;
        #1;
        checks++;
        if (bus.csr_rdata !== 32'd3) begin
            errors++;
            $display("FAIL ebreak_mcause got %h exp 3", bus.csr_rdata);
        end
        bus.retire = 1'b1;
        csr_write(12'hB02, 32'd10);
        bus.retire = 1'b0;
        #1;
        checks++;
        if (bus.csr_rdata !== 32'd10) begin
            errors++;
            $display("FAIL minstret_wr_wins got %h exp a", bus.csr_rdata);
        end
    endtask

    task automatic test_async_reset;
        logic [11:0] a [5];
        logic [31:0] e [5];
        csr_write(12'h340, 32'hCAFE_F00D);
        bus.ecall = 1'b1;
        bus.pc    = 32'h0000_0400;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.redirect !== 1'b0) begin
            errors++;
            $display("FAIL arst_redirect got %b exp 0", bus.redirect);
        end
        bus.ecall = 1'b0;
        a = '{12'h340, 12'h305, 12'h341, 12'h342, 12'h300};
        e = '{32'h0, 32'h40, 32'h0, 32'h0, 32'h1800};
        for (int i = 0; i < 5; i++) begin
            bus.csr_addr = a[i];
            #0.5;
            checks++;
            if (bus.csr_rdata !== e[i]) begin
                errors++;
                $display("FAIL arst_rd_%h got %h exp %h",
                         a[i], bus.csr_rdata, e[i]);
            end
        end
        tick();
        rst_n = 1'b1;
        tick();
        bus.csr_addr = 12'hB00;
        #1;
        checks++;
        if (bus.csr_rdata !== 32'd1) begin
            errors++;
            $display("FAIL arst_mcycle got %h exp 1", bus.csr_rdata);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();
        #12;
        test_reset();
        test_csrrw();
        test_csrrwi();
        test_trap();
        test_counters();
        test_conflicts();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
